// File: rtl/mem_write_arbiter.sv
// Two-master round-robin arbiter for one single-beat memory write port (aw/w/b).
// Grants whole transactions (address, data, response) with no interleaving between masters.
module mem_write_arbiter #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // master 0 (memory_filler)
  input  logic                 m0_aw_valid,
  output logic                 m0_aw_ready,
  input  logic [ADDR_WDTH-1:0] m0_aw_address,
  input  logic                 m0_w_valid,
  output logic                 m0_w_ready,
  input  logic [DATA_WDTH-1:0] m0_w_data,
  output logic                 m0_b_valid,
  output logic [RESP_WDTH-1:0] m0_b_resp,
  input  logic                 m0_b_ready,
  // master 1 (sorter write-back)
  input  logic                 m1_aw_valid,
  output logic                 m1_aw_ready,
  input  logic [ADDR_WDTH-1:0] m1_aw_address,
  input  logic                 m1_w_valid,
  output logic                 m1_w_ready,
  input  logic [DATA_WDTH-1:0] m1_w_data,
  output logic                 m1_b_valid,
  output logic [RESP_WDTH-1:0] m1_b_resp,
  input  logic                 m1_b_ready,
  // memory side
  output logic                 s_aw_valid,
  input  logic                 s_aw_ready,
  output logic [ADDR_WDTH-1:0] s_aw_address,
  output logic                 s_w_valid,
  input  logic                 s_w_ready,
  output logic [DATA_WDTH-1:0] s_w_data,
  input  logic                 s_b_valid,
  input  logic [RESP_WDTH-1:0] s_b_resp,
  output logic                 s_b_ready,
  // status
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 wr_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_next;
  logic [1:0] grant_next;
  logic       last, last_next;
  logic       aw_done, aw_done_next;
  logic       w_done, w_done_next;
  logic       wr_err_next;

  logic                 g_aw_valid, g_w_valid, g_b_ready;
  logic [ADDR_WDTH-1:0] g_aw_address;
  logic [DATA_WDTH-1:0] g_w_data;
  logic                 aw_hs, w_hs, b_hs;

  // Signals of whichever master currently owns the port; all zero without a grant.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    g_aw_valid   = 1'b0;
    g_aw_address = '0;
    g_w_valid    = 1'b0;
    g_w_data     = '0;
    g_b_ready    = 1'b0;
    if (grant[0]) begin
      g_aw_valid   = m0_aw_valid;
      g_aw_address = m0_aw_address;
      g_w_valid    = m0_w_valid;
      g_w_data     = m0_w_data;
      g_b_ready    = m0_b_ready;
    end else if (grant[1]) begin
      g_aw_valid   = m1_aw_valid;
      g_aw_address = m1_aw_address;
      g_w_valid    = m1_w_valid;
      g_w_data     = m1_w_data;
      g_b_ready    = m1_b_ready;
    end
  end

  assign aw_hs = (state == XFER) && g_aw_valid && s_aw_ready && !aw_done;
  assign w_hs  = (state == XFER) && g_w_valid  && s_w_ready  && !w_done;
  assign b_hs  = (state == RESP) && s_b_valid  && g_b_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      last    <= last_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
      wr_err  <= wr_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    last_next    = last;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    wr_err_next  = wr_err;
    unique case (state)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_aw_valid && (!m1_aw_valid || last)) begin
          grant_next = 2'b01;
          state_next = XFER;
        end else if (m1_aw_valid) begin
          grant_next = 2'b10;
          state_next = XFER;
        end
      end
      XFER: begin
        aw_done_next = aw_done || aw_hs;
        w_done_next  = w_done  || w_hs;
        if (aw_done_next && w_done_next) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          wr_err_next = wr_err || (s_b_resp != '0);
          last_next   = grant[1];
          grant_next  = 2'b00;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_aw_valid   = 1'b0;
    s_w_valid    = 1'b0;
    s_b_ready    = 1'b0;
    s_aw_address = g_aw_address;
    s_w_data     = g_w_data;
    m0_aw_ready  = 1'b0;
    m0_w_ready   = 1'b0;
    m0_b_valid   = 1'b0;
    m0_b_resp    = '0;
    m1_aw_ready  = 1'b0;
    m1_w_ready   = 1'b0;
    m1_b_valid   = 1'b0;
    m1_b_resp    = '0;
    case (state)
      XFER: begin
        s_aw_valid  = g_aw_valid && !aw_done;
        s_w_valid   = g_w_valid  && !w_done;
        m0_aw_ready = grant[0] && s_aw_ready && !aw_done;
        m0_w_ready  = grant[0] && s_w_ready  && !w_done;
        m1_aw_ready = grant[1] && s_aw_ready && !aw_done;
        m1_w_ready  = grant[1] && s_w_ready  && !w_done;
      end
      RESP: begin
        s_b_ready  = g_b_ready;
        m0_b_valid = grant[0] && s_b_valid;
        m1_b_valid = grant[1] && s_b_valid;
        m0_b_resp  = grant[0] ? s_b_resp : '0;
        m1_b_resp  = grant[1] ? s_b_resp : '0;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: single writes, round-robin ties, split handshakes,
// response back-pressure, sticky error flag and asynchronous reset mid-transaction.
module tb_mem_write_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_aw_valid = 0, m0_aw_ready, m0_w_valid = 0, m0_w_ready, m0_b_valid, m0_b_ready = 0;
  logic [AW-1:0] m0_aw_address = '0;
  logic [DW-1:0] m0_w_data = '0;
  logic [RW-1:0] m0_b_resp;
  logic          m1_aw_valid = 0, m1_aw_ready, m1_w_valid = 0, m1_w_ready, m1_b_valid, m1_b_ready = 0;
  logic [AW-1:0] m1_aw_address = '0;
  logic [DW-1:0] m1_w_data = '0;
  logic [RW-1:0] m1_b_resp;
  logic          s_aw_valid, s_aw_ready = 0, s_w_valid, s_w_ready = 0, s_b_valid = 0, s_b_ready;
  logic [AW-1:0] s_aw_address;
  logic [DW-1:0] s_w_data;
  logic [RW-1:0] s_b_resp = '0;
  logic [1:0]    grant;
  logic          busy, wr_err;

  mem_write_arbiter #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_address(m0_aw_address),
    .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_data(m0_w_data),
    .m0_b_valid(m0_b_valid), .m0_b_resp(m0_b_resp), .m0_b_ready(m0_b_ready),
    .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_address(m1_aw_address),
    .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data),
    .m1_b_valid(m1_b_valid), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_address(s_aw_address),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
    .grant(grant), .busy(busy), .wr_err(wr_err)
  );

  int checks = 0;
  int passes = 0;

  // Negedge monitor: inputs change only just after posedge, so these values equal the edge values.
  bit            hs0_aw, hs0_w, hs1_aw, hs1_w;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [1:0]    grant_log[$];
  logic [1:0]    prev_grant;
  int            w_ready1_cnt = 0;
  int            s_w_valid_cnt = 0;

  always @(negedge clk) begin
    hs0_aw <= m0_aw_valid && m0_aw_ready;
    hs0_w  <= m0_w_valid  && m0_w_ready;
    hs1_aw <= m1_aw_valid && m1_aw_ready;
    hs1_w  <= m1_w_valid  && m1_w_ready;
    if (s_aw_valid && s_aw_ready) aw_log.push_back(s_aw_address);
    if (s_w_valid && s_w_ready) w_log.push_back(s_w_data);
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
    prev_grant <= grant;
    if (m1_w_ready) w_ready1_cnt <= w_ready1_cnt + 1;
    if (s_w_valid) s_w_valid_cnt <= s_w_valid_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; masters drop valids that handshook at the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hs0_aw) m0_aw_valid = 1'b0;
    if (hs0_w)  m0_w_valid  = 1'b0;
    if (hs1_aw) m1_aw_valid = 1'b0;
    if (hs1_w)  m1_w_valid  = 1'b0;
  endtask

  task automatic clear_inputs();
    m0_aw_valid = 0; m0_w_valid = 0; m0_b_ready = 0; m0_aw_address = '0; m0_w_data = '0;
    m1_aw_valid = 0; m1_w_valid = 0; m1_b_ready = 0; m1_aw_address = '0; m1_w_data = '0;
    s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mem_always_ready(input logic [RW-1:0] resp);
    s_aw_ready = 1; s_w_ready = 1; s_b_valid = 1; s_b_resp = resp;
    m0_b_ready = 1; m1_b_ready = 1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      if (!busy && !m0_aw_valid && !m1_aw_valid && !m0_w_valid && !m1_w_valid) done = 1;
    end
    checks++;
    if (!done) $display("FAIL %s_timeout: busy=%b after %0d cycles, required idle", name, busy, budget);
    else passes++;
  endtask

  task automatic single_write(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [RW-1:0] resp, input string name);
    mem_always_ready(resp);
    if (!m) begin
      m0_aw_valid = 1; m0_aw_address = a; m0_w_valid = 1; m0_w_data = d;
    end else begin
      m1_aw_valid = 1; m1_aw_address = a; m1_w_valid = 1; m1_w_data = d;
    end
    wait_idle(20, name);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m0_aw_valid = 1; m1_aw_valid = 1; s_aw_ready = 1; s_w_ready = 1; s_b_valid = 1;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b required 00", grant); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passes++;
    checks++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b required 0", wr_err); else passes++;
    checks++;
    if ({s_aw_valid, s_w_valid, s_b_ready, m0_aw_ready, m0_w_ready, m0_b_valid,
         m1_aw_ready, m1_w_ready, m1_b_valid} !== 9'b0)
      $display("FAIL reset_handshake_outputs: got %b required 000000000",
               {s_aw_valid, s_w_valid, s_b_ready, m0_aw_ready, m0_w_ready, m0_b_valid,
                m1_aw_ready, m1_w_ready, m1_b_valid});
    else passes++;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_m0();
    mem_always_ready('0);
    m0_aw_valid = 1; m0_aw_address = 4'd3; m0_w_valid = 1; m0_w_data = 32'hDEADBEEF;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL single_grant_req_cycle: got %b required 00", grant); else passes++;
    checks++; if (s_aw_valid !== 1'b0) $display("FAIL single_idle_aw_valid: got %b required 0", s_aw_valid); else passes++;
    tick();
    checks++; if (grant !== 2'b01) $display("FAIL single_grant: got %b required 01", grant); else passes++;
    checks++;
    if (s_aw_valid !== 1'b1 || s_aw_address !== 4'd3 || m0_aw_ready !== 1'b1)
      $display("FAIL single_aw: valid=%b addr=%h ready=%b required 1/3/1", s_aw_valid, s_aw_address, m0_aw_ready);
    else passes++;
    checks++;
    if (s_w_valid !== 1'b1 || s_w_data !== 32'hDEADBEEF)
      $display("FAIL single_w: valid=%b data=%h required 1/deadbeef", s_w_valid, s_w_data);
    else passes++;
    tick();
    checks++;
    if (m0_b_valid !== 1'b1 || m0_b_resp !== 1'b0 || s_b_ready !== 1'b1)
      $display("FAIL single_b: valid=%b resp=%b s_b_ready=%b required 1/0/1", m0_b_valid, m0_b_resp, s_b_ready);
    else passes++;
    tick();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL single_release: grant=%b busy=%b required 00/0", grant, busy); else passes++;
    checks++; if (wr_err !== 1'b0) $display("FAIL single_wr_err: got %b required 0", wr_err); else passes++;
  endtask

  task automatic test_round_robin();
    int            base_aw, base_w, base_g;
    logic [AW-1:0] exp_a[4];
    logic [DW-1:0] exp_d[4];
    logic [1:0]    exp_g[4];
    logic [AW-1:0] got_a;
    logic [DW-1:0] got_d;
    logic [1:0]    got_g;
    clear_inputs();
    do_reset();
    base_aw = aw_log.size(); base_w = w_log.size(); base_g = grant_log.size();
    for (int r = 0; r < 2; r++) begin
      mem_always_ready('0);
      m0_aw_valid = 1; m0_aw_address = AW'(1 + r); m0_w_valid = 1; m0_w_data = 32'hA000_0000 + DW'(r);
      m1_aw_valid = 1; m1_aw_address = AW'(8 + r); m1_w_valid = 1; m1_w_data = 32'hB000_0000 + DW'(r);
      wait_idle(30, "rr");
    end
    exp_a = '{4'd1, 4'd8, 4'd2, 4'd9};
    exp_d = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    checks++;
    if (aw_log.size() - base_aw != 4 || w_log.size() - base_w != 4)
      $display("FAIL rr_write_count: aw=%0d w=%0d required 4/4", aw_log.size() - base_aw, w_log.size() - base_w);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      got_a = (base_aw + i < aw_log.size()) ? aw_log[base_aw + i] : 'x;
      got_d = (base_w + i < w_log.size()) ? w_log[base_w + i] : 'x;
      got_g = (base_g + i < grant_log.size()) ? grant_log[base_g + i] : 'x;
      checks++;
      if (got_a !== exp_a[i] || got_d !== exp_d[i])
        $display("FAIL rr_write%0d: addr=%h data=%h required %h/%h", i, got_a, got_d, exp_a[i], exp_d[i]);
      else passes++;
      checks++;
      if (got_g !== exp_g[i]) $display("FAIL rr_grant%0d: got %b required %b", i, got_g, exp_g[i]);
      else passes++;
    end
  endtask

  task automatic test_w_before_aw();
    int base_wr, base_wv;
    clear_inputs();
    base_wr = w_ready1_cnt; base_wv = s_w_valid_cnt;
    s_aw_ready = 0; s_w_ready = 1; s_b_valid = 1; m1_b_ready = 1;
    m1_aw_valid = 1; m1_aw_address = 4'd12; m1_w_valid = 1; m1_w_data = 32'h1234_5678;
    tick();
    checks++;
    if (grant !== 2'b10 || m1_w_ready !== 1'b1 || m1_aw_ready !== 1'b0)
      $display("FAIL split_first: grant=%b w_ready=%b aw_ready=%b required 10/1/0", grant, m1_w_ready, m1_aw_ready);
    else passes++;
    tick();
    checks++;
    if (s_w_valid !== 1'b0 || m1_w_ready !== 1'b0 || m1_b_valid !== 1'b0)
      $display("FAIL split_wait: s_w_valid=%b w_ready=%b b_valid=%b required 0/0/0", s_w_valid, m1_w_ready, m1_b_valid);
    else passes++;
    tick();
    tick();
    s_aw_ready = 1;
    #1;
    checks++;
    if (busy !== 1'b1 || m1_b_valid !== 1'b0 || m1_aw_ready !== 1'b1 || s_aw_address !== 4'd12)
      $display("FAIL split_aw: busy=%b b_valid=%b aw_ready=%b addr=%h required 1/0/1/c",
               busy, m1_b_valid, m1_aw_ready, s_aw_address);
    else passes++;
    tick();
    checks++; if (m1_b_valid !== 1'b1) $display("FAIL split_resp: b_valid=%b required 1", m1_b_valid); else passes++;
    checks++;
    if (w_ready1_cnt - base_wr != 1 || s_w_valid_cnt - base_wv != 1)
      $display("FAIL split_w_once: w_ready cycles=%0d s_w_valid cycles=%0d required 1/1",
               w_ready1_cnt - base_wr, s_w_valid_cnt - base_wv);
    else passes++;
    tick();
    checks++; if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL split_done: busy=%b grant=%b required 0/00", busy, grant); else passes++;
  endtask

  task automatic test_b_backpressure();
    clear_inputs();
    s_aw_ready = 1; s_w_ready = 1; s_b_valid = 1; m0_b_ready = 0; m1_b_ready = 1;
    m0_aw_valid = 1; m0_aw_address = 4'd4; m0_w_valid = 1; m0_w_data = 32'h0000_0044;
    tick();
    m1_aw_valid = 1; m1_aw_address = 4'd5; m1_w_valid = 1; m1_w_data = 32'h0000_0055;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (grant !== 2'b01 || m0_b_valid !== 1'b1 || s_b_ready !== 1'b0 || m1_aw_ready !== 1'b0)
        $display("FAIL bp_stall%0d: grant=%b b_valid=%b s_b_ready=%b m1_aw_ready=%b required 01/1/0/0",
                 i, grant, m0_b_valid, s_b_ready, m1_aw_ready);
      else passes++;
      tick();
    end
    m0_b_ready = 1;
    #1;
    checks++; if (s_b_ready !== 1'b1) $display("FAIL bp_release: s_b_ready=%b required 1", s_b_ready); else passes++;
    tick();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL bp_bubble: grant=%b busy=%b required 00/0", grant, busy); else passes++;
    tick();
    checks++; if (grant !== 2'b10) $display("FAIL bp_m1_grant: got %b required 10", grant); else passes++;
    wait_idle(20, "bp");
  endtask

  task automatic test_error();
    clear_inputs();
    single_write(1'b0, 4'd6, 32'h0000_1111, 1'b1, "err_write");
    checks++; if (wr_err !== 1'b1) $display("FAIL err_set: got %b required 1", wr_err); else passes++;
    single_write(1'b1, 4'd7, 32'h0000_2222, 1'b0, "err_ok1");
    single_write(1'b0, 4'd8, 32'h0000_3333, 1'b0, "err_ok2");
    checks++; if (wr_err !== 1'b1) $display("FAIL err_sticky: got %b required 1", wr_err); else passes++;
    clear_inputs();
    do_reset();
    checks++; if (wr_err !== 1'b0) $display("FAIL err_reset: got %b required 0", wr_err); else passes++;
  endtask

  task automatic test_reset_mid_xfer();
    clear_inputs();
    s_aw_ready = 1; s_w_ready = 0; s_b_valid = 0; m1_b_ready = 1;
    m1_aw_valid = 1; m1_aw_address = 4'd10; m1_w_valid = 1; m1_w_data = 32'hCAFE_0001;
    tick();
    checks++; if (m1_aw_ready !== 1'b1) $display("FAIL mid_aw_hs: aw_ready=%b required 1", m1_aw_ready); else passes++;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || s_w_valid !== 1'b0 || m1_w_ready !== 1'b0 ||
        s_aw_valid !== 1'b0 || s_aw_address !== '0 || s_w_data !== '0)
      $display("FAIL mid_reset_outputs: grant=%b busy=%b s_w_valid=%b w_ready=%b s_aw_valid=%b addr=%h data=%h required all 0",
               grant, busy, s_w_valid, m1_w_ready, s_aw_valid, s_aw_address, s_w_data);
    else passes++;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_always_ready('0);
    m0_aw_valid = 1; m0_aw_address = 4'd1; m0_w_valid = 1; m0_w_data = 32'h0000_00A1;
    m1_aw_valid = 1; m1_aw_address = 4'd2; m1_w_valid = 1; m1_w_data = 32'h0000_00B2;
    tick();
    checks++; if (grant !== 2'b01) $display("FAIL mid_restart_tie: grant=%b required 01", grant); else passes++;
    wait_idle(30, "mid_restart");
    checks++; if (wr_err !== 1'b0) $display("FAIL mid_wr_err: got %b required 0", wr_err); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_round_robin();
    test_w_before_aw();
    test_b_backpressure();
    test_error();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
